// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multicycle MIPS control path: decoded opcodes,
//   ALUOp encodings (also consumed by the ALU control block), ALU operand B
//   and PC source mux encodings, and the main control state enum.
package mips_pkg;

  localparam int CTRL_ST_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [CTRL_ST_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM of the multicycle MIPS datapath. Sequences
//   fetch/decode/execute/memory/writeback from the IR opcode and drives all
//   datapath mux selects and enables. Memory accesses wait on mem_ready.
//
//   state  | meaning
//   FETCH  | read instruction, PC+4; advance when memory ready
//   DECODE | register read, branch target precompute, dispatch on opcode
//   MEMADR | effective address for LW/SW
//   MEMRD  | data read, held until memory ready
//   MEMWB  | MDR -> rt
//   MEMWR  | data write, held until memory ready
//   EXEC   | R-type ALU operation
//   ALUWB  | ALUOut -> rd
//   BRANCH | compare for beq, conditional PC load from ALUOut
//   JUMP   | PC <- jump target
//   ADDIEX | A + signext(imm)
//   ADDIWB | ALUOut -> rt
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   opcode           instr[31:26]
//   zero             ALU zero flag (branch gating happens in the datapath)
//   mem_ready        memory completes the current access this cycle
//   PCWrite..PCSource datapath controls
//   illegal          one-cycle pulse on unsupported opcode or bad state
//   state_o          current state, debug only
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int ST_W = CTRL_ST_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal,
  output logic [ST_W-1:0] state_o
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  // zero is consumed by the datapath's PCWriteCond gating, not here.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  assign state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal     = 1'b0;

    case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        if (mem_ready) begin
          IRWrite     = 1'b1;
          PCWrite     = 1'b1;
          PCSource    = PCSRC_ALU;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        ALUOp   = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: w_state_nxt = ST_MEMADR;
          OP_RTYPE:     w_state_nxt = ST_EXEC;
          OP_BEQ:       w_state_nxt = ST_BRANCH;
          OP_J:         w_state_nxt = ST_JUMP;
          OP_ADDI:      w_state_nxt = ST_ADDIEX;
          default: begin
            w_state_nxt = ST_FETCH;
            illegal     = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALUOP_ADD;
        // Anything but SW is treated as the load path.
        w_state_nxt = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_state_nxt = ST_MEMWB;
      end
      ST_MEMWB: begin
        MemtoReg    = 1'b1;
        RegWrite    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_state_nxt = ST_FETCH;
      end
      ST_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_RTYPE;
        w_state_nxt = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegDst      = 1'b1;
        RegWrite    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        w_state_nxt = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite     = 1'b1;
        PCSource    = PCSRC_JUMP;
        w_state_nxt = ST_FETCH;
      end
      ST_ADDIEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALUOP_ADD;
        w_state_nxt = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        RegWrite    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      default: begin
        // Encodings 12..15 are unreachable; recover and flag.
        illegal     = 1'b1;
        w_state_nxt = ST_FETCH;
      end
    endcase

    // Reset kills any in-flight request immediately, not just at the edge.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Drives instruction scenarios cycle by cycle. Each cycle the expected state
//   and control word are pushed to a scoreboard queue as the inputs are
//   applied, then popped and compared against the DUT mid-cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPW(6), .ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal
  function automatic logic [16:0] exp_ctl(input int s, input bit mr,
                                          input logic [5:0] op, input bit r);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!r) begin
      case (s)
        0:  begin mrd = 1; srcb = 2'b01; if (mr) begin irw = 1; pcw = 1; end end
        1:  begin srcb = 2'b11;
                  ill = !(op == RT || op == LW || op == SW || op == BEQ ||
                          op == J || op == ADI); end
        2:  begin srca = 1; srcb = 2'b10; end
        3:  begin iord = 1; mrd = 1; end
        4:  begin m2r = 1; rw = 1; end
        5:  begin iord = 1; mwr = 1; end
        6:  begin srca = 1; aop = 2'b10; end
        7:  begin rdst = 1; rw = 1; end
        8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
        9:  begin pcw = 1; pcs = 2'b10; end
        10: begin srca = 1; srcb = 2'b10; end
        11: begin rw = 1; end
        default: ill = 1;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
  endfunction

  // Called just after a rising edge: apply inputs for this cycle, record the
  // expectation, compare mid-cycle, then advance to the next edge.
  task automatic step(input int s, input bit mr, input logic [5:0] op, input bit r);
    exp_t e, p;
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    zero      = 1'($urandom_range(0, 1));
    e.st  = 4'(s);
    e.ctl = exp_ctl(s, mr, op, r);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      p = sb_q.pop_front();
      chk("state", 32'(state_o), 32'(p.st));
      chk("ctrl", 32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                       PCSource, illegal}), 32'(p.ctl));
    end
    chk("mem_excl", 32'(MemRead & MemWrite), 32'd0);
    chk("wr_excl", 32'(RegWrite & (PCWrite | PCWriteCond)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = RT; zero = 1'b0;
    @(posedge clk);
    #1;
    // Reset held two cycles, outputs forced low even with mem_ready high.
    step(0, 1, RT, 1);
    step(0, 1, RT, 1);

    // R-type; opcode changes during EXEC/ALUWB must not matter.
    step(0, 1, RT, 0);
    step(1, 1, RT, 0);
    step(6, 0, LW, 0);
    step(7, 1, J, 0);

    // LW with two wait states in MEMRD.
    step(0, 1, LW, 0);
    step(1, 0, LW, 0);
    step(2, 1, LW, 0);
    step(3, 0, LW, 0);
    step(3, 0, LW, 0);
    step(3, 1, LW, 0);
    step(4, 1, LW, 0);

    // BEQ, then J.
    step(0, 1, BEQ, 0);
    step(1, 1, BEQ, 0);
    step(8, 1, BEQ, 0);
    step(0, 1, J, 0);
    step(1, 1, J, 0);
    step(9, 1, J, 0);

    // Unsupported opcode: one illegal pulse, straight back to FETCH.
    step(0, 1, BAD, 0);
    step(1, 1, BAD, 0);

    // ADDI with a stalled fetch.
    step(0, 0, ADI, 0);
    step(0, 1, ADI, 0);
    step(1, 1, ADI, 0);
    step(10, 1, ADI, 0);
    step(11, 1, ADI, 0);

    // SW completing normally after one wait.
    step(0, 1, SW, 0);
    step(1, 1, SW, 0);
    step(2, 1, SW, 0);
    step(5, 0, SW, 0);
    step(5, 1, SW, 0);

    // SW aborted by reset while the write is stalled.
    step(0, 1, SW, 0);
    step(1, 1, SW, 0);
    step(2, 1, SW, 0);
    step(5, 0, SW, 0);
    step(5, 0, SW, 1);
    step(0, 0, SW, 0);
    step(0, 1, RT, 0);
    step(1, 1, RT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
